// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NUM_REQ requesters.
// The winner's counter runs from 0 up to its latched interval, then it gets a one-cycle done pulse.
module timer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]  req_val_i,
  input  logic                          pause_i,
  input  logic                          abort_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [CNT_WIDTH-1:0]          count_out_o,
  output logic                          rollover_flag_o
);

  // state   | meaning
  // S_IDLE  | counter free, arbitrating among requests
  // S_COUNT | counter running for the granted owner
  // S_DONE  | interval reached, done pulse to owner for one cycle
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NR_L   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_L = PTR_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] val_q, val_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     own_q, own_d;

  logic [CNT_WIDTH-1:0] vals [NUM_REQ];
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       sum;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [PTR_W-1:0]     own_next;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vals[i] = req_val_i[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // First set request searching upward from the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= NR_L) sum = sum - NR_L;
      if (!win_found && req_i[sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PTR_W-1:0];
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign own_next   = (own_q == LAST_L) ? '0 : own_q + PTR_W'(1);
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          own_d   = win_idx;
          val_d   = vals[win_idx];
          cnt_d   = '0;
          if (vals[win_idx] == '0) begin
            state_d = S_DONE;
            done_d  = win_onehot;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        // abort wins over both pause and reaching the interval
        if (abort_i) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = own_next;
        end else if (!pause_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == val_q) begin
            state_d = S_DONE;
            done_d  = grant_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
        ptr_d   = own_next;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign count_out_o     = cnt_q;
  assign busy_o          = (state_q != S_IDLE);
  assign rollover_flag_o = (state_q != S_IDLE) && (cnt_q == val_q);

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_timer_arbiter;

  localparam int NR = 4;
  localparam int CW = 4;
  localparam int OW = 2*NR + 1 + CW + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_i;
  logic [NR*CW-1:0] req_val_i;
  logic             pause_i;
  logic             abort_i;
  logic [NR-1:0]    grant_o;
  logic             busy_o;
  logic [NR-1:0]    done_o;
  logic [CW-1:0]    count_out_o;
  logic             rollover_flag_o;

  int errors = 0;
  int checks = 0;
  int vals [NR];
  logic [OW-1:0] obs;

  always #5 clk_i = ~clk_i;

  timer_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_val_i(req_val_i),
    .pause_i(pause_i), .abort_i(abort_i), .grant_o(grant_o), .busy_o(busy_o),
    .done_o(done_o), .count_out_o(count_out_o), .rollover_flag_o(rollover_flag_o)
  );

  // observed bundle: {grant, done, busy, count, rollover}
  assign obs = {grant_o, done_o, busy_o, count_out_o, rollover_flag_o};

  function automatic logic [OW-1:0] ev(input logic [NR-1:0] g, input logic [NR-1:0] d,
                                       input logic b, input logic [CW-1:0] c, input logic r);
    return {g, d, b, c, r};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_vals;
    for (int i = 0; i < NR; i++) req_val_i[i*CW +: CW] = CW'(vals[i]);
  endtask

  task automatic do_reset;
    rst_i = 1'b1; req_i = '0; pause_i = 1'b0; abort_i = 1'b0;
    tick;
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < NR; i++) vals[i] = 7;
    set_vals;
    req_i = '1; abort_i = 1'b0; pause_i = 1'b0; rst_i = 1'b1;
    tick;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset: got=%h exp=%h", obs, {OW{1'b0}});
    end
    rst_i = 1'b0; req_i = '0;
  endtask

  task automatic test_basic;
    logic [OW-1:0] exp;
    do_reset;
    vals = '{3, 0, 0, 0}; set_vals;
    req_i = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      tick;
      if (e == 1) req_i = '0;
      if (e < 4)       exp = ev(4'b0001, 4'b0000, 1'b1, CW'(e-1), 1'b0);
      else if (e == 4) exp = ev(4'b0001, 4'b0001, 1'b1, CW'(3), 1'b1);
      else             exp = '0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_rr;
    int eg [8] = '{1, 1, 1, 0, 4, 4, 0, 1};
    int ed [8] = '{0, 0, 1, 0, 0, 4, 0, 0};
    int ec [8] = '{0, 1, 2, 0, 0, 1, 0, 0};
    int er [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    logic [OW-1:0] exp;
    do_reset;
    vals = '{2, 9, 1, 9}; set_vals;
    req_i = 4'b0101;
    for (int e = 0; e < 8; e++) begin
      tick;
      exp = ev(NR'(eg[e]), NR'(ed[e]), eg[e] != 0, CW'(ec[e]), er[e] != 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rr e%0d: got=%h exp=%h", e+1, obs, exp);
      end
    end
    req_i = '0;
  endtask

  task automatic test_zero;
    logic [OW-1:0] exp;
    do_reset;
    vals = '{5, 5, 5, 0}; set_vals;
    req_i = 4'b1000;
    for (int e = 1; e <= 2; e++) begin
      tick;
      req_i = '0;
      exp = (e == 1) ? ev(4'b1000, 4'b1000, 1'b1, '0, 1'b1) : '0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
  endtask

  task automatic test_pause;
    int ec [9] = '{0, 1, 2, 2, 2, 2, 3, 4, 0};
    logic [OW-1:0] exp;
    do_reset;
    vals = '{4, 0, 0, 0}; set_vals;
    req_i = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      pause_i = (e >= 4 && e <= 6);
      tick;
      req_i = '0;
      if (e == 9)      exp = '0;
      else if (e == 8) exp = ev(4'b0001, 4'b0001, 1'b1, CW'(4), 1'b1);
      else             exp = ev(4'b0001, 4'b0000, 1'b1, CW'(ec[e-1]), 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pause e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
    pause_i = 1'b0;
  endtask

  task automatic test_abort;
    logic [OW-1:0] exp;
    // abort mid-interval, then the next requester in order wins
    do_reset;
    vals = '{5, 1, 0, 0}; set_vals;
    req_i = 4'b0011;
    for (int e = 1; e <= 7; e++) begin
      abort_i = (e == 5);
      tick;
      if (e <= 4)      exp = ev(4'b0001, 4'b0000, 1'b1, CW'(e-1), 1'b0);
      else if (e == 5) exp = '0;
      else if (e == 6) exp = ev(4'b0010, 4'b0000, 1'b1, '0, 1'b0);
      else             exp = ev(4'b0010, 4'b0010, 1'b1, CW'(1), 1'b1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_mid e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
    abort_i = 1'b0;
    // abort on the same edge the count would reach the interval
    do_reset;
    vals = '{2, 1, 0, 0}; set_vals;
    req_i = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      abort_i = (e == 3);
      if (e == 4) req_i = 4'b0011;
      tick;
      if (e <= 2)      exp = ev(4'b0001, 4'b0000, 1'b1, CW'(e-1), 1'b0);
      else if (e == 3) exp = '0;
      else             exp = ev(4'b0010, 4'b0000, 1'b1, '0, 1'b0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_edge e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
    abort_i = 1'b0; req_i = '0;
  endtask

  task automatic test_rst_mid;
    logic [OW-1:0] exp;
    do_reset;
    vals = '{0, 5, 0, 0}; set_vals;
    req_i = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      if (e == 3) begin
        req_i = 4'b0011;
        vals = '{5, 5, 0, 0}; set_vals;
      end
      rst_i = (e == 6);
      tick;
      case (e)
        1:       exp = ev(4'b0001, 4'b0001, 1'b1, '0, 1'b1);
        3, 4, 5: exp = ev(4'b0010, 4'b0000, 1'b1, CW'(e-3), 1'b0);
        7:       exp = ev(4'b0001, 4'b0000, 1'b1, '0, 1'b0);
        default: exp = '0;
      endcase
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rst_mid e%0d: got=%h exp=%h", e, obs, exp);
      end
    end
    rst_i = 1'b0; req_i = '0;
  endtask

  task automatic test_random;
    int m_ptr, w, v, cnt, guard, rqi, j;
    logic ab, ps;
    logic [NR-1:0] oh;
    logic [OW-1:0] exp;
    do_reset;
    m_ptr = 0;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_i = '0;
        abort_i = 1'($urandom_range(0, 1));
        pause_i = 1'($urandom_range(0, 1));
        tick;
        checks++;
        if (obs !== '0) begin
          errors++;
          $display("FAIL rand_idle t%0d: got=%h exp=%h", t, obs, {OW{1'b0}});
        end
      end
      for (int i = 0; i < NR; i++)
        vals[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << CW) - 1))
                                              : int'($urandom_range(0, 5));
      set_vals;
      rqi = int'($urandom_range(1, (1 << NR) - 1));
      req_i = NR'(rqi);
      abort_i = 1'($urandom_range(0, 1));
      pause_i = 1'($urandom_range(0, 1));
      w = -1;
      for (int i = 0; i < NR; i++) begin
        j = (m_ptr + i) % NR;
        if (w < 0 && ((rqi >> j) & 1) == 1) w = j;
      end
      v  = vals[w];
      oh = NR'(1 << w);
      tick;
      exp = ev(oh, (v == 0) ? oh : '0, 1'b1, '0, v == 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand_grant t%0d: got=%h exp=%h", t, obs, exp);
      end
      req_i = NR'($urandom_range(0, (1 << NR) - 1));
      cnt = 0; ab = 1'b0; guard = 0;
      while (v != 0 && cnt < v && !ab && guard < 200) begin
        guard++;
        ps = ($urandom_range(0, 3) == 0);
        ab = ($urandom_range(0, 19) == 0);
        pause_i = ps; abort_i = ab;
        tick;
        if (ab) exp = '0;
        else begin
          if (!ps) cnt++;
          exp = ev(oh, (cnt == v) ? oh : '0, 1'b1, CW'(cnt), cnt == v);
        end
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL rand_count t%0d: got=%h exp=%h", t, obs, exp);
        end
      end
      if (!ab) begin
        abort_i = 1'($urandom_range(0, 1));
        pause_i = 1'($urandom_range(0, 1));
        req_i = NR'($urandom_range(0, (1 << NR) - 1));
        tick;
        checks++;
        if (obs !== '0) begin
          errors++;
          $display("FAIL rand_release t%0d: got=%h exp=%h", t, obs, {OW{1'b0}});
        end
      end
      m_ptr = (w + 1) % NR;
      abort_i = 1'b0; pause_i = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1; req_i = '0; req_val_i = '0; pause_i = 1'b0; abort_i = 1'b0;
    test_reset;
    test_basic;
    test_rr;
    test_zero;
    test_pause;
    test_abort;
    test_rst_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
